// File: rtl/vga_pkg.sv
// ============================================================================
// Module   : vga_pkg
// Purpose  : Shared game-state encoding, counter/score widths and a small
//            saturating-free score increment helper used by the game FSM,
//            the text overlay and the ball logic.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  // Game state encoding shared by every block that reacts to the game phase.
  typedef enum logic [1:0] {
    MENU_START = 2'b00,
    SERVE      = 2'b01,
    PLAYING    = 2'b10,
    GAME_OVER  = 2'b11
  } state_t;

  localparam int c_CNT_W   = 10;
  localparam int c_SCORE_W = 4;

  typedef logic [c_SCORE_W-1:0] score_t;
  typedef logic [c_CNT_W-1:0]   frame_cnt_t;

  // Scores never overflow because the match ends at WIN_SCORE <= 15.
  function automatic score_t score_inc(input score_t s);
    return s + score_t'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/game_fsm_if.sv
// ============================================================================
// Module   : game_fsm_if
// Purpose  : Bundles the game controller's event inputs and status outputs.
// Ports    : start_btn, frame_tick, p1_point, p2_point (events into the FSM)
//            state, player1_score, player2_score, ball_hold, serve_dir
//            (status out of the FSM)
//            modport slave  - the game FSM side
//            modport master - the side that produces events / consumes status
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface game_fsm_if;
  import vga_pkg::*;

  logic   start_btn;
  logic   frame_tick;
  logic   p1_point;
  logic   p2_point;
  state_t state;
  score_t player1_score;
  score_t player2_score;
  logic   ball_hold;
  logic   serve_dir;

  modport slave (
    input  start_btn, frame_tick, p1_point, p2_point,
    output state, player1_score, player2_score, ball_hold, serve_dir
  );

  modport master (
    output start_btn, frame_tick, p1_point, p2_point,
    input  state, player1_score, player2_score, ball_hold, serve_dir
  );

endinterface

`default_nettype wire

// File: rtl/game_timer.sv
// ============================================================================
// Module   : game_timer
// Purpose  : Frame-tick counter with synchronous clear, count enable and a
//            terminal-count input. o_done pulses on the enabled tick that
//            brings the count up to i_tc; the owner clears the counter on
//            that same edge, so the count never wraps.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            i_clr         - synchronous clear (wins over i_en)
//            i_en          - count enable (one frame tick)
//            i_tc          - terminal count
//            o_done        - combinational terminal-count pulse
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_timer
  import vga_pkg::*;
(
  input  wire logic       clk,
  input  wire logic       rst,
  input  wire logic       i_clr,
  input  wire logic       i_en,
  input  wire frame_cnt_t i_tc,
  output logic            o_done
);

  frame_cnt_t r_count;
  frame_cnt_t w_count_inc;

  assign w_count_inc = r_count + frame_cnt_t'(1);

  // Done looks at the incremented value so the transition fires on the tick
  // that makes the count equal the terminal value. It does not depend on
  // i_clr, which keeps the owner's clear logic free of a combinational loop.
  assign o_done = i_en && (w_count_inc == i_tc);

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_count_inc;
    end
  end

endmodule

`default_nettype wire

// File: rtl/game_fsm.sv
// ============================================================================
// Module   : game_fsm
// Purpose  : Pong match controller. Sequences MENU_START -> SERVE ->
//            PLAYING -> (SERVE | GAME_OVER) -> MENU_START, keeps the two
//            4-bit scores, the serve direction and the ball-park flag.
//            All outputs are registers updated on the edge that samples the
//            causing input.
// Ports    : clk   - system pixel clock
//            rst   - synchronous active-high reset
//            bus   - game_fsm_if.slave (start_btn, frame_tick, p1_point,
//                    p2_point in; state, scores, ball_hold, serve_dir out)
// Params   : WIN_SCORE (1..15), SERVE_FRAMES (1..1023), OVER_FRAMES (1..1023)
// Config   : GAME_AUTO_RESTART_EN - when defined, GAME_OVER also returns to
//            MENU_START after OVER_FRAMES frame ticks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module game_fsm
  import vga_pkg::*;
#(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned OVER_FRAMES  = 300
) (
  input wire logic  clk,
  input wire logic  rst,
  game_fsm_if.slave bus
);

  localparam score_t     c_WIN      = score_t'(WIN_SCORE);
  localparam frame_cnt_t c_SERVE_TC = frame_cnt_t'(SERVE_FRAMES);
  localparam frame_cnt_t c_OVER_TC  = frame_cnt_t'(OVER_FRAMES);

`ifdef GAME_AUTO_RESTART_EN
  localparam logic c_AUTO_RESTART = 1'b1;
`else
  localparam logic c_AUTO_RESTART = 1'b0;
`endif

  // Registered state
  state_t r_state;
  score_t r_p1_score;
  score_t r_p2_score;
  logic   r_serve_dir;
  logic   r_ball_hold;
  logic   r_start_prev;

  // Next-state values
  state_t w_state;
  score_t w_p1_score;
  score_t w_p2_score;
  logic   w_serve_dir;
  logic   w_ball_hold;

  logic       w_start_ev;
  logic       w_tmr_clr;
  logic       w_tmr_en;
  logic       w_tmr_done;
  frame_cnt_t w_tmr_tc;

  assign w_start_ev = bus.start_btn && !r_start_prev;

  // The timer only runs in SERVE, and in GAME_OVER when auto-restart is
  // built in; elsewhere it sits at the zero it was cleared to on entry.
  assign w_tmr_en = bus.frame_tick &&
                    ((r_state == SERVE) ||
                     (c_AUTO_RESTART && (r_state == GAME_OVER)));
  assign w_tmr_tc = (r_state == GAME_OVER) ? c_OVER_TC : c_SERVE_TC;

  game_timer u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_tmr_clr),
    .i_en   (w_tmr_en),
    .i_tc   (w_tmr_tc),
    .o_done (w_tmr_done)
  );

  always_comb begin
    w_state     = r_state;
    w_p1_score  = r_p1_score;
    w_p2_score  = r_p2_score;
    w_serve_dir = r_serve_dir;

    unique case (r_state)
      MENU_START: begin
        if (w_start_ev) begin
          w_state     = SERVE;
          w_p1_score  = '0;
          w_p2_score  = '0;
          w_serve_dir = 1'b0;
        end
      end

      SERVE: begin
        if (w_tmr_done) begin
          w_state = PLAYING;
        end
      end

      PLAYING: begin
        // Player 1 has priority on a simultaneous point; player 2's is lost.
        if (bus.p1_point) begin
          w_p1_score  = score_inc(r_p1_score);
          w_serve_dir = 1'b1;
          w_state     = (w_p1_score == c_WIN) ? GAME_OVER : SERVE;
        end else if (bus.p2_point) begin
          w_p2_score  = score_inc(r_p2_score);
          w_serve_dir = 1'b0;
          w_state     = (w_p2_score == c_WIN) ? GAME_OVER : SERVE;
        end
      end

      GAME_OVER: begin
        if (w_start_ev || w_tmr_done) begin
          w_state = MENU_START;
        end
      end

      default: begin
        w_state = MENU_START;
      end
    endcase

    // Every state change restarts the frame counter from zero.
    w_tmr_clr   = (w_state != r_state);
    w_ball_hold = (w_state != PLAYING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= MENU_START;
      r_p1_score   <= '0;
      r_p2_score   <= '0;
      r_serve_dir  <= 1'b0;
      r_ball_hold  <= 1'b1;
      r_start_prev <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_p1_score   <= w_p1_score;
      r_p2_score   <= w_p2_score;
      r_serve_dir  <= w_serve_dir;
      r_ball_hold  <= w_ball_hold;
      r_start_prev <= bus.start_btn;
    end
  end

  assign bus.state         = r_state;
  assign bus.player1_score = r_p1_score;
  assign bus.player2_score = r_p2_score;
  assign bus.ball_hold     = r_ball_hold;
  assign bus.serve_dir     = r_serve_dir;

endmodule

`default_nettype wire

// File: tb/tb_game_fsm.sv
// ============================================================================
// Module   : tb_game_fsm
// Purpose  : Self-checking bench for game_fsm. A rule-level model of the
//            match is compared with the DUT on every falling edge, and
//            hand-computed literal values pin the model at key points.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_game_fsm;

  localparam int WIN = 9;
  localparam int SF  = 60;
  localparam int OF  = 300;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_fsm_if u_if ();

  game_fsm #(
    .WIN_SCORE    (WIN),
    .SERVE_FRAMES (SF),
    .OVER_FRAMES  (OF)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------
  // Match model: phase 0=menu 1=serve 2=playing 3=over, plain integers.
  // --------------------------------------------------------------------
  int m_phase, m_s1, m_s2, m_dir, m_frames;
  bit m_btn_last;

  always @(posedge clk) begin
    bit started;
    if (rst) begin
      m_phase = 0; m_s1 = 0; m_s2 = 0; m_dir = 0; m_frames = 0;
      m_btn_last = 1'b0;
    end else begin
      started = u_if.start_btn && !m_btn_last;
      m_btn_last = u_if.start_btn;
      case (m_phase)
        0: if (started) begin
             m_phase = 1; m_s1 = 0; m_s2 = 0; m_dir = 0; m_frames = 0;
           end
        1: if (u_if.frame_tick) begin
             m_frames++;
             if (m_frames == SF) begin m_phase = 2; m_frames = 0; end
           end
        2: begin
             if (u_if.p1_point) begin
               m_s1++; m_dir = 1; m_frames = 0;
               m_phase = (m_s1 == WIN) ? 3 : 1;
             end else if (u_if.p2_point) begin
               m_s2++; m_dir = 0; m_frames = 0;
               m_phase = (m_s2 == WIN) ? 3 : 1;
             end
           end
        default: begin
             if (started) begin
               m_phase = 0; m_frames = 0;
             end
`ifdef GAME_AUTO_RESTART_EN
             else if (u_if.frame_tick) begin
               m_frames++;
               if (m_frames == OF) begin m_phase = 0; m_frames = 0; end
             end
`endif
           end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("state",     int'(u_if.state),         m_phase);
      check("p1_score",  int'(u_if.player1_score), m_s1);
      check("p2_score",  int'(u_if.player2_score), m_s2);
      check("ball_hold", int'(u_if.ball_hold),     (m_phase != 2) ? 1 : 0);
      check("serve_dir", int'(u_if.serve_dir),     m_dir);
    end
  end

  // --------------------------------------------------------------------
  // Stimulus helpers (inputs change on the falling edge)
  // --------------------------------------------------------------------
  task automatic pulse_tick();
    @(negedge clk) u_if.frame_tick = 1'b1;
    @(negedge clk) u_if.frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) pulse_tick();
  endtask

  task automatic press_start();
    @(negedge clk) u_if.start_btn = 1'b1;
    @(negedge clk) u_if.start_btn = 1'b0;
  endtask

  task automatic point(input bit a, input bit b);
    @(negedge clk) begin u_if.p1_point = a; u_if.p2_point = b; end
    @(negedge clk) begin u_if.p1_point = 1'b0; u_if.p2_point = 1'b0; end
  endtask

  task automatic lit(input string name, input int s, input int a, input int b,
                     input int hold, input int dir);
    check({name, ".state"}, int'(u_if.state),         s);
    check({name, ".p1"},    int'(u_if.player1_score), a);
    check({name, ".p2"},    int'(u_if.player2_score), b);
    check({name, ".hold"},  int'(u_if.ball_hold),     hold);
    check({name, ".dir"},   int'(u_if.serve_dir),     dir);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    u_if.start_btn = 1'b0; u_if.frame_tick = 1'b0;
    u_if.p1_point  = 1'b0; u_if.p2_point   = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    lit("reset", 0, 0, 0, 1, 0);
    rst = 1'b0;

    // Start edge with the button held afterwards.
    @(negedge clk) u_if.start_btn = 1'b1;
    @(negedge clk);
    lit("start", 1, 0, 0, 1, 0);
    ticks(SF - 1);
    check("serve_59", int'(u_if.state), 1);
    pulse_tick();
    lit("serve_60", 2, 0, 0, 0, 0);
    u_if.start_btn = 1'b0;

    // Player 1 runs the match to WIN.
    for (int i = 1; i <= WIN; i++) begin
      point(1'b1, 1'b0);
      check("p1_run", int'(u_if.player1_score), i);
      if (i < WIN) ticks(SF);
    end
    lit("p1_win", 3, 9, 0, 1, 1);

`ifdef GAME_AUTO_RESTART_EN
    ticks(OF - 1);
    check("over_299", int'(u_if.state), 3);
    pulse_tick();
    lit("auto_menu", 0, 9, 0, 1, 1);
`else
    ticks(1000);
    lit("over_1000", 3, 9, 0, 1, 1);
    press_start();
    lit("over_start", 0, 9, 0, 1, 1);
`endif

    // New match to 3/3, then a simultaneous point.
    press_start();
    lit("restart", 1, 0, 0, 1, 0);
    ticks(SF);
    for (int i = 0; i < 3; i++) begin
      point(1'b1, 1'b0); ticks(SF);
      point(1'b0, 1'b1); ticks(SF);
    end
    lit("tie33", 2, 3, 3, 0, 0);
    point(1'b1, 1'b1);
    lit("simul", 1, 4, 3, 1, 1);

    // Point pulses and a start edge in SERVE are ignored.
    @(negedge clk) begin u_if.p2_point = 1'b1; u_if.start_btn = 1'b1; end
    @(negedge clk) begin u_if.p2_point = 1'b0; u_if.start_btn = 1'b0; end
    point(1'b1, 1'b0);
    lit("serve_ign", 1, 4, 3, 1, 1);

    // Fresh match to 5/2, then reset during PLAYING with the button held.
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    press_start();
    point(1'b0, 1'b0);
    ticks(SF);
    point(1'b1, 1'b0); ticks(SF);
    point(1'b0, 1'b1); ticks(SF);
    point(1'b1, 1'b0); ticks(SF);
    point(1'b0, 1'b1); ticks(SF);
    point(1'b1, 1'b0); ticks(SF);
    point(1'b1, 1'b0); ticks(SF);
    point(1'b1, 1'b0); ticks(SF);
    lit("at52", 2, 5, 2, 0, 1);
    @(negedge clk) begin rst = 1'b1; u_if.start_btn = 1'b1; end
    @(negedge clk) rst = 1'b0;
    lit("mid_rst", 0, 0, 0, 1, 0);
    @(negedge clk);
    lit("held_btn", 1, 0, 0, 1, 0);
    u_if.start_btn = 1'b0;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
